// File: rtl/bin_state_xfer.sv
// Moves one bin's variable/level states between the global state RAMs and state_list.
// LOAD streams RAM reads into engine write strobes; STORE writes a start-cycle snapshot back to RAM.
module bin_state_xfer #(
    parameter int unsigned NUM_VARS         = 8,
    parameter int unsigned NUM_LVLS         = 8,
    parameter int unsigned WIDTH_VAR_STATES = 17,
    parameter int unsigned WIDTH_LVL_STATES = 11,
    parameter int unsigned WIDTH_LVL        = 16,
    parameter int unsigned WIDTH_BIN        = 10,
    parameter int unsigned WIDTH_VIDX       = 3,
    parameter int unsigned WIDTH_LIDX       = 3
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start_load_i,
    input  logic                                   start_store_i,
    input  logic [WIDTH_BIN-1:0]                   bin_num_i,
    input  logic [WIDTH_LVL-1:0]                   base_lvl_i,
    output logic                                   busy_o,
    output logic                                   done_load_o,
    output logic                                   done_store_o,
    output logic [WIDTH_BIN+WIDTH_VIDX-1:0]        var_ram_addr_o,
    output logic                                   var_ram_re_o,
    output logic                                   var_ram_we_o,
    output logic [WIDTH_VAR_STATES-1:0]            var_ram_wdata_o,
    input  logic [WIDTH_VAR_STATES-1:0]            var_ram_rdata_i,
    output logic [WIDTH_BIN+WIDTH_LIDX-1:0]        lvl_ram_addr_o,
    output logic                                   lvl_ram_re_o,
    output logic                                   lvl_ram_we_o,
    output logic [WIDTH_LVL_STATES-1:0]            lvl_ram_wdata_o,
    input  logic [WIDTH_LVL_STATES-1:0]            lvl_ram_rdata_i,
    output logic [NUM_VARS-1:0]                    wr_var_states_o,
    output logic [WIDTH_VAR_STATES*NUM_VARS-1:0]   vars_states_o,
    output logic [NUM_LVLS-1:0]                    wr_lvl_states_o,
    output logic [WIDTH_LVL_STATES*NUM_LVLS-1:0]   lvl_states_o,
    output logic                                   base_lvl_en_o,
    output logic [WIDTH_LVL-1:0]                   base_lvl_o,
    input  logic [WIDTH_VAR_STATES*NUM_VARS-1:0]   vars_states_i,
    input  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0]   lvl_states_i
);

    localparam int unsigned N         = (NUM_VARS > NUM_LVLS) ? NUM_VARS : NUM_LVLS;
    localparam int unsigned WIDTH_CNT = (N > 1) ? $clog2(N) : 1;
    localparam logic [WIDTH_CNT:0] NV_L  = (WIDTH_CNT+1)'(NUM_VARS);
    localparam logic [WIDTH_CNT:0] NL_L  = (WIDTH_CNT+1)'(NUM_LVLS);
    localparam logic [WIDTH_CNT-1:0] LAST = WIDTH_CNT'(N - 1);

    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, LDONE, STORE, SDONE} state_t;

    state_t                                     state_q;
    logic [WIDTH_CNT-1:0]                       cnt_q, cnt_d;
    logic [WIDTH_BIN-1:0]                       bin_q;
    logic [NUM_VARS-1:0][WIDTH_VAR_STATES-1:0]  var_snap_q;
    logic [NUM_LVLS-1:0][WIDTH_LVL_STATES-1:0]  lvl_snap_q;
    logic                                       busy_q, done_load_q, done_store_q, base_lvl_en_q;
    logic [WIDTH_LVL-1:0]                       base_lvl_q;
    logic                                       var_re_q, var_we_q, lvl_re_q, lvl_we_q;
    logic [WIDTH_BIN+WIDTH_VIDX-1:0]            var_addr_q;
    logic [WIDTH_BIN+WIDTH_LIDX-1:0]            lvl_addr_q;
    logic [WIDTH_VAR_STATES-1:0]                var_wdata_q;
    logic [WIDTH_LVL_STATES-1:0]                lvl_wdata_q;
    logic                                       var_vld_q, lvl_vld_q;
    logic [WIDTH_VIDX-1:0]                      var_idx_q;
    logic [WIDTH_LIDX-1:0]                      lvl_idx_q;

    logic [NUM_VARS-1:0][WIDTH_VAR_STATES-1:0]  var_in_c, var_slots_c;
    logic [NUM_LVLS-1:0][WIDTH_LVL_STATES-1:0]  lvl_in_c, lvl_slots_c;
    logic [WIDTH_CNT-1:0]                       step_cnt_c;
    logic [WIDTH_VIDX-1:0]                      vidx_c;
    logic [WIDTH_LIDX-1:0]                      lidx_c;
    logic                                       var_act_c, lvl_act_c;
    logic [WIDTH_VAR_STATES-1:0]                var_wdata_c;
    logic [WIDTH_LVL_STATES-1:0]                lvl_wdata_c;

    assign var_in_c = vars_states_i;
    assign lvl_in_c = lvl_states_i;
    assign cnt_d    = cnt_q + WIDTH_CNT'(1);

    // Element index issued on the next cycle: 0 when starting, cnt+1 while stepping.
    assign step_cnt_c  = (state_q == IDLE) ? '0 : cnt_d;
    assign vidx_c      = WIDTH_VIDX'(step_cnt_c);
    assign lidx_c      = WIDTH_LIDX'(step_cnt_c);
    assign var_act_c   = {1'b0, step_cnt_c} < NV_L;
    assign lvl_act_c   = {1'b0, step_cnt_c} < NL_L;
    assign var_wdata_c = (state_q == IDLE) ? var_in_c[0] : var_snap_q[vidx_c];
    assign lvl_wdata_c = (state_q == IDLE) ? lvl_in_c[0] : lvl_snap_q[lidx_c];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            bin_q         <= '0;
            var_snap_q    <= '0;
            lvl_snap_q    <= '0;
            busy_q        <= 1'b0;
            done_load_q   <= 1'b0;
            done_store_q  <= 1'b0;
            base_lvl_en_q <= 1'b0;
            base_lvl_q    <= '0;
            var_re_q      <= 1'b0;
            var_we_q      <= 1'b0;
            lvl_re_q      <= 1'b0;
            lvl_we_q      <= 1'b0;
            var_addr_q    <= '0;
            lvl_addr_q    <= '0;
            var_wdata_q   <= '0;
            lvl_wdata_q   <= '0;
            var_vld_q     <= 1'b0;
            lvl_vld_q     <= 1'b0;
            var_idx_q     <= '0;
            lvl_idx_q     <= '0;
        end else begin
            var_re_q      <= 1'b0;
            var_we_q      <= 1'b0;
            lvl_re_q      <= 1'b0;
            lvl_we_q      <= 1'b0;
            var_addr_q    <= '0;
            lvl_addr_q    <= '0;
            var_wdata_q   <= '0;
            lvl_wdata_q   <= '0;
            done_load_q   <= 1'b0;
            done_store_q  <= 1'b0;
            base_lvl_en_q <= 1'b0;
            // Read-return pipeline: data arrives the cycle after the read enable.
            var_vld_q     <= var_re_q;
            lvl_vld_q     <= lvl_re_q;
            var_idx_q     <= var_addr_q[WIDTH_VIDX-1:0];
            lvl_idx_q     <= lvl_addr_q[WIDTH_LIDX-1:0];

            case (state_q)
                IDLE: begin
                    if (start_load_i) begin
                        state_q    <= LOAD;
                        cnt_q      <= '0;
                        bin_q      <= bin_num_i;
                        base_lvl_q <= base_lvl_i;
                        busy_q     <= 1'b1;
                        var_re_q   <= var_act_c;
                        lvl_re_q   <= lvl_act_c;
                        var_addr_q <= var_act_c ? {bin_num_i, vidx_c} : '0;
                        lvl_addr_q <= lvl_act_c ? {bin_num_i, lidx_c} : '0;
                    end else if (start_store_i) begin
                        state_q     <= STORE;
                        cnt_q       <= '0;
                        bin_q       <= bin_num_i;
                        var_snap_q  <= var_in_c;
                        lvl_snap_q  <= lvl_in_c;
                        busy_q      <= 1'b1;
                        var_we_q    <= var_act_c;
                        lvl_we_q    <= lvl_act_c;
                        var_addr_q  <= var_act_c ? {bin_num_i, vidx_c} : '0;
                        lvl_addr_q  <= lvl_act_c ? {bin_num_i, lidx_c} : '0;
                        var_wdata_q <= var_act_c ? var_wdata_c : '0;
                        lvl_wdata_q <= lvl_act_c ? lvl_wdata_c : '0;
                    end
                end
                LOAD: begin
                    if (cnt_q == LAST) begin
                        state_q <= DRAIN;
                    end else begin
                        cnt_q      <= cnt_d;
                        var_re_q   <= var_act_c;
                        lvl_re_q   <= lvl_act_c;
                        var_addr_q <= var_act_c ? {bin_q, vidx_c} : '0;
                        lvl_addr_q <= lvl_act_c ? {bin_q, lidx_c} : '0;
                    end
                end
                DRAIN: begin
                    state_q       <= LDONE;
                    done_load_q   <= 1'b1;
                    base_lvl_en_q <= 1'b1;
                end
                STORE: begin
                    if (cnt_q == LAST) begin
                        state_q      <= SDONE;
                        done_store_q <= 1'b1;
                    end else begin
                        cnt_q       <= cnt_d;
                        var_we_q    <= var_act_c;
                        lvl_we_q    <= lvl_act_c;
                        var_addr_q  <= var_act_c ? {bin_q, vidx_c} : '0;
                        lvl_addr_q  <= lvl_act_c ? {bin_q, lidx_c} : '0;
                        var_wdata_q <= var_act_c ? var_wdata_c : '0;
                        lvl_wdata_q <= lvl_act_c ? lvl_wdata_c : '0;
                    end
                end
                LDONE, SDONE: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Engine-side write port is driven straight from RAM read data.
    always_comb begin
        wr_var_states_o = '0;
        wr_lvl_states_o = '0;
        var_slots_c     = '0;
        lvl_slots_c     = '0;
        if (var_vld_q) begin
            wr_var_states_o[var_idx_q] = 1'b1;
            var_slots_c[var_idx_q]     = var_ram_rdata_i;
        end
        if (lvl_vld_q) begin
            wr_lvl_states_o[lvl_idx_q] = 1'b1;
            lvl_slots_c[lvl_idx_q]     = lvl_ram_rdata_i;
        end
    end

    assign vars_states_o   = var_slots_c;
    assign lvl_states_o    = lvl_slots_c;
    assign busy_o          = busy_q;
    assign done_load_o     = done_load_q;
    assign done_store_o    = done_store_q;
    assign base_lvl_en_o   = base_lvl_en_q;
    assign base_lvl_o      = base_lvl_q;
    assign var_ram_addr_o  = var_addr_q;
    assign var_ram_re_o    = var_re_q;
    assign var_ram_we_o    = var_we_q;
    assign var_ram_wdata_o = var_wdata_q;
    assign lvl_ram_addr_o  = lvl_addr_q;
    assign lvl_ram_re_o    = lvl_re_q;
    assign lvl_ram_we_o    = lvl_we_q;
    assign lvl_ram_wdata_o = lvl_wdata_q;

endmodule
